// File: rtl/gds_alloc_controller.sv
// rtl/gds_alloc_controller.sv - GDS resource table request-side alloc/dealloc controller
module gds_alloc_controller #(
    parameter int NUMBER_CU            = 64,
    parameter int CU_ID_WIDTH          = 6,
    parameter int WG_SLOT_ID_WIDTH     = 6,
    parameter int RES_TABLE_ADDR_WIDTH = 3,
    parameter int GDS_ID_WIDTH         = 10,
    parameter int GDS_SIZE             = 1024,
    parameter int SETTLE_CYCLES        = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            alloc_req_valid,
    output logic                            alloc_req_ready,
    input  logic [CU_ID_WIDTH-1:0]          alloc_req_cu_id,
    input  logic [WG_SLOT_ID_WIDTH-1:0]     alloc_req_wg_id,
    input  logic [GDS_ID_WIDTH:0]           alloc_req_gds_size,
    output logic                            alloc_resp_valid,
    output logic                            alloc_resp_granted,
    input  logic                            dealloc_req_valid,
    input  logic [CU_ID_WIDTH-1:0]          dealloc_req_cu_id,
    input  logic [WG_SLOT_ID_WIDTH-1:0]     dealloc_req_wg_id,
    output logic                            dealloc_ack,
    output logic                            gds_res_tbl_alloc_en,
    output logic                            gds_res_tbl_dealloc_en,
    output logic [CU_ID_WIDTH-1:0]          gds_res_tbl_cu_id,
    output logic [WG_SLOT_ID_WIDTH-1:0]     gds_res_tbl_wg_id,
    output logic [GDS_ID_WIDTH:0]           gds_res_tbl_alloc_gds_size,
    output logic [RES_TABLE_ADDR_WIDTH-1:0] gds_res_tbl_inflight_res_tbl_id,
    input  logic [GDS_ID_WIDTH:0]           gds_res_tbl_wg_gds_size
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    // Reject configurations the table cannot represent or that break the settle timing
    if (NUMBER_CU > (1 << CU_ID_WIDTH)) begin : g_bad_cu_cfg
        $error("NUMBER_CU does not fit in CU_ID_WIDTH");
    end
    if (GDS_SIZE >= (1 << (GDS_ID_WIDTH + 1))) begin : g_bad_gds_cfg
        $error("GDS_SIZE does not fit in GDS_ID_WIDTH+1 bits");
    end
    if (SETTLE_CYCLES < 4) begin : g_bad_settle_cfg
        $error("SETTLE_CYCLES must be at least 4");
    end

    typedef enum logic {
        S_IDLE,
        S_SETTLE
    } state_t;

    state_t                          state, state_nxt;
    logic [CNT_W-1:0]                cnt, cnt_nxt;
    logic                            alloc_en_nxt, dealloc_en_nxt, ack_nxt;
    logic                            resp_valid_nxt, resp_granted_nxt;
    logic [CU_ID_WIDTH-1:0]          cu_id_nxt;
    logic [WG_SLOT_ID_WIDTH-1:0]     wg_id_nxt;
    logic [GDS_ID_WIDTH:0]           size_nxt;
    logic [RES_TABLE_ADDR_WIDTH-1:0] tbl_id_nxt;

    // Next-state and next-output decision; dealloc wins over alloc, strobes default low, ids hold
    always_comb begin
        state_nxt        = state;
        cnt_nxt          = cnt;
        alloc_req_ready  = 1'b0;
        alloc_en_nxt     = 1'b0;
        dealloc_en_nxt   = 1'b0;
        ack_nxt          = 1'b0;
        resp_valid_nxt   = 1'b0;
        resp_granted_nxt = 1'b0;
        cu_id_nxt        = gds_res_tbl_cu_id;
        wg_id_nxt        = gds_res_tbl_wg_id;
        size_nxt         = gds_res_tbl_alloc_gds_size;
        tbl_id_nxt       = gds_res_tbl_inflight_res_tbl_id;
        case (state)
            S_SETTLE: begin
                cnt_nxt = cnt - CNT_ONE;
                if (cnt == CNT_ONE) begin
                    state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                alloc_req_ready = !dealloc_req_valid;
                if (dealloc_req_valid) begin
                    dealloc_en_nxt = 1'b1;
                    ack_nxt        = 1'b1;
                    cu_id_nxt      = dealloc_req_cu_id;
                    wg_id_nxt      = dealloc_req_wg_id;
                    tbl_id_nxt     = dealloc_req_cu_id[RES_TABLE_ADDR_WIDTH-1:0];
                    cnt_nxt        = SETTLE_LOAD;
                    state_nxt      = S_SETTLE;
                end else if (alloc_req_valid) begin
                    resp_valid_nxt = 1'b1;
                    // A rejection leaves the free space untouched, so no settle is needed
                    if (alloc_req_gds_size <= gds_res_tbl_wg_gds_size) begin
                        resp_granted_nxt = 1'b1;
                        alloc_en_nxt     = 1'b1;
                        cu_id_nxt        = alloc_req_cu_id;
                        wg_id_nxt        = alloc_req_wg_id;
                        size_nxt         = alloc_req_gds_size;
                        tbl_id_nxt       = alloc_req_cu_id[RES_TABLE_ADDR_WIDTH-1:0];
                        cnt_nxt          = SETTLE_LOAD;
                        state_nxt        = S_SETTLE;
                    end
                end
            end
            default: begin
                state_nxt = S_SETTLE;
                cnt_nxt   = SETTLE_LOAD;
            end
        endcase
    end

    // State, settle counter and registered outputs; reset waits out the table's zero free space
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                           <= S_SETTLE;
            cnt                             <= SETTLE_LOAD;
            gds_res_tbl_alloc_en            <= 1'b0;
            gds_res_tbl_dealloc_en          <= 1'b0;
            dealloc_ack                     <= 1'b0;
            alloc_resp_valid                <= 1'b0;
            alloc_resp_granted              <= 1'b0;
            gds_res_tbl_cu_id               <= '0;
            gds_res_tbl_wg_id               <= '0;
            gds_res_tbl_alloc_gds_size      <= '0;
            gds_res_tbl_inflight_res_tbl_id <= '0;
        end else begin
            state                           <= state_nxt;
            cnt                             <= cnt_nxt;
            gds_res_tbl_alloc_en            <= alloc_en_nxt;
            gds_res_tbl_dealloc_en          <= dealloc_en_nxt;
            dealloc_ack                     <= ack_nxt;
            alloc_resp_valid                <= resp_valid_nxt;
            alloc_resp_granted              <= resp_granted_nxt;
            gds_res_tbl_cu_id               <= cu_id_nxt;
            gds_res_tbl_wg_id               <= wg_id_nxt;
            gds_res_tbl_alloc_gds_size      <= size_nxt;
            gds_res_tbl_inflight_res_tbl_id <= tbl_id_nxt;
        end
    end

endmodule

// File: tb/tb_gds_alloc_controller.sv
// tb/tb_gds_alloc_controller.sv - self-checking bench for gds_alloc_controller
module tb_gds_alloc_controller;

    localparam int GDS_SIZE = 1024;
    localparam int SETTLE   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alloc_req_valid = 1'b0;
    logic        alloc_req_ready;
    logic [5:0]  alloc_req_cu_id = '0;
    logic [5:0]  alloc_req_wg_id = '0;
    logic [10:0] alloc_req_gds_size = '0;
    logic        alloc_resp_valid;
    logic        alloc_resp_granted;
    logic        dealloc_req_valid = 1'b0;
    logic [5:0]  dealloc_req_cu_id = '0;
    logic [5:0]  dealloc_req_wg_id = '0;
    logic        dealloc_ack;
    logic        tbl_alloc_en;
    logic        tbl_dealloc_en;
    logic [5:0]  tbl_cu_id;
    logic [5:0]  tbl_wg_id;
    logic [10:0] tbl_alloc_size;
    logic [2:0]  tbl_id;
    logic [10:0] tbl_free_out;

    gds_alloc_controller dut (
        .clk                             (clk),
        .rst                             (rst),
        .alloc_req_valid                 (alloc_req_valid),
        .alloc_req_ready                 (alloc_req_ready),
        .alloc_req_cu_id                 (alloc_req_cu_id),
        .alloc_req_wg_id                 (alloc_req_wg_id),
        .alloc_req_gds_size              (alloc_req_gds_size),
        .alloc_resp_valid                (alloc_resp_valid),
        .alloc_resp_granted              (alloc_resp_granted),
        .dealloc_req_valid               (dealloc_req_valid),
        .dealloc_req_cu_id               (dealloc_req_cu_id),
        .dealloc_req_wg_id               (dealloc_req_wg_id),
        .dealloc_ack                     (dealloc_ack),
        .gds_res_tbl_alloc_en            (tbl_alloc_en),
        .gds_res_tbl_dealloc_en          (tbl_dealloc_en),
        .gds_res_tbl_cu_id               (tbl_cu_id),
        .gds_res_tbl_wg_id               (tbl_wg_id),
        .gds_res_tbl_alloc_gds_size      (tbl_alloc_size),
        .gds_res_tbl_inflight_res_tbl_id (tbl_id),
        .gds_res_tbl_wg_gds_size         (tbl_free_out)
    );

    always #5 clk = ~clk;

    // Resource table stand-in: zero free space out of reset, then a two-stage lag on every change
    int tbl_free;
    int tbl_d1;
    int tbl_d2;
    bit tbl_init;
    int tbl_slot [0:4095];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tbl_free <= 0;
            tbl_d1   <= 0;
            tbl_d2   <= 0;
            tbl_init <= 1'b0;
        end else begin
            if (!tbl_init) begin
                tbl_free <= GDS_SIZE;
                tbl_init <= 1'b1;
            end else begin
                tbl_free <= tbl_free + tbl_d2;
            end
            tbl_d2 <= tbl_d1;
            if (tbl_alloc_en) begin
                tbl_d1 <= -int'(tbl_alloc_size);
                tbl_slot[{tbl_cu_id, tbl_wg_id}] <= int'(tbl_alloc_size);
            end else if (tbl_dealloc_en) begin
                tbl_d1 <= tbl_slot[{tbl_cu_id, tbl_wg_id}];
            end else begin
                tbl_d1 <= 0;
            end
        end
    end

    assign tbl_free_out = 11'(tbl_free);

    int errors = 0;
    int checks = 0;

    // Reference model: outstanding allocations and earliest cycle for the next accepted handshake
    int edge_idx;
    int next_ok;
    int used;
    int live_q[$];
    int live_sz[int];
    int exp_cu;
    int exp_wg;
    int exp_size;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        edge_idx = 0;
        next_ok  = SETTLE;
        used     = 0;
        live_q.delete();
        live_sz.delete();
        exp_cu   = 0;
        exp_wg   = 0;
        exp_size = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_alloc_en"}, tbl_alloc_en, 0);
        chk({tag, "_dealloc_en"}, tbl_dealloc_en, 0);
        chk({tag, "_resp_valid"}, alloc_resp_valid, 0);
        chk({tag, "_granted"}, alloc_resp_granted, 0);
        chk({tag, "_ack"}, dealloc_ack, 0);
        chk({tag, "_ready"}, alloc_req_ready, 0);
        chk({tag, "_cu"}, tbl_cu_id, 0);
        chk({tag, "_wg"}, tbl_wg_id, 0);
        chk({tag, "_size"}, tbl_alloc_size, 0);
        chk({tag, "_tid"}, tbl_id, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        alloc_req_valid = 1'b1;
        alloc_req_gds_size = 11'd1;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("rst");
        rst = 1'b0;
        model_reset();
    endtask

    // One clock: drive, check ready before the edge, check registered outputs after it
    task automatic do_cycle(input bit av, input int acu, input int awg, input int asz,
                            input bit dv, input int dcu, input int dwg,
                            output bit hs_a, output bit hs_d);
        bit idle;
        bit g;
        int key;
        alloc_req_valid    = av;
        alloc_req_cu_id    = 6'(acu);
        alloc_req_wg_id    = 6'(awg);
        alloc_req_gds_size = 11'(asz);
        dealloc_req_valid  = dv;
        dealloc_req_cu_id  = 6'(dcu);
        dealloc_req_wg_id  = 6'(dwg);
        #1;
        idle = (edge_idx >= next_ok);
        chk("ready", alloc_req_ready, idle && !dv);
        hs_d = idle && dv;
        hs_a = idle && !dv && av;
        g    = hs_a && (asz <= GDS_SIZE - used);
        @(posedge clk);
        #1;
        chk("dealloc_en", tbl_dealloc_en, hs_d);
        chk("dealloc_ack", dealloc_ack, hs_d);
        chk("alloc_en", tbl_alloc_en, g);
        chk("resp_valid", alloc_resp_valid, hs_a);
        chk("resp_granted", alloc_resp_granted, g);
        if (hs_d) begin
            key = dcu * 64 + dwg;
            used -= live_sz[key];
            live_sz.delete(key);
            for (int i = 0; i < live_q.size(); i++) begin
                if (live_q[i] == key) begin
                    live_q.delete(i);
                    break;
                end
            end
            exp_cu  = dcu;
            exp_wg  = dwg;
            next_ok = edge_idx + SETTLE + 1;
        end else if (g) begin
            key = acu * 64 + awg;
            used += asz;
            live_sz[key] = asz;
            live_q.push_back(key);
            exp_cu   = acu;
            exp_wg   = awg;
            exp_size = asz;
            next_ok  = edge_idx + SETTLE + 1;
        end
        chk("tbl_cu_id", tbl_cu_id, exp_cu);
        chk("tbl_wg_id", tbl_wg_id, exp_wg);
        chk("tbl_size", tbl_alloc_size, exp_size);
        chk("tbl_id", tbl_id, exp_cu % 8);
        edge_idx++;
    endtask

    task automatic alloc_until(input int cu, input int wg, input int sz);
        bit ha;
        bit hd;
        int n;
        ha = 1'b0;
        n  = 0;
        while (!ha && n < 16) begin
            do_cycle(1'b1, cu, wg, sz, 1'b0, 0, 0, ha, hd);
            n++;
        end
        chk("alloc_handshake_bound", ha, 1);
    endtask

    task automatic dealloc_until(input int cu, input int wg);
        bit ha;
        bit hd;
        int n;
        hd = 1'b0;
        n  = 0;
        while (!hd && n < 16) begin
            do_cycle(1'b1, 20, 20, 1, 1'b1, cu, wg, ha, hd);
            n++;
        end
        chk("dealloc_handshake_bound", hd, 1);
    endtask

    initial begin
        bit ha;
        bit hd;
        bit av;
        bit dv;
        int cu;
        int wg;
        int sz;
        int r;
        int dkey;

        // Reset release with a request already pending; first decision sees the full 1024
        do_reset();
        alloc_until(3, 5, 100);
        // Oversized request rejected; the very next cycle handshakes again
        alloc_until(7, 1, 1025);
        do_cycle(1'b1, 7, 2, 900, 1'b0, 0, 0, ha, hd);
        chk("ready_after_reject", ha, 1);
        // Exact fit, then one word too many, then a zero-size grant
        alloc_until(7, 3, 24);
        alloc_until(7, 4, 1);
        alloc_until(7, 5, 0);
        // Dealloc beats a concurrent alloc; the alloc then sees the released space
        dealloc_until(3, 5);
        alloc_until(9, 9, 100);
        dealloc_until(7, 5);
        dealloc_until(7, 2);
        // Reset arriving right after a granted alloc drops the in-flight strobe and response
        alloc_until(10, 10, 50);
        rst = 1'b1;
        #1;
        chk("midrst_alloc_en", tbl_alloc_en, 0);
        chk("midrst_resp_valid", alloc_resp_valid, 0);
        chk("midrst_granted", alloc_resp_granted, 0);
        chk("midrst_ready", alloc_req_ready, 0);
        do_reset();
        alloc_until(11, 11, 1024);
        alloc_until(12, 12, 1);
        dealloc_until(11, 11);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            cu = int'($urandom_range(0, 63));
            wg = int'($urandom_range(0, 63));
            r  = int'($urandom_range(0, 9));
            if (r < 1)      sz = 0;
            else if (r < 3) sz = GDS_SIZE - used;
            else if (r < 4) sz = GDS_SIZE - used + 1;
            else            sz = int'($urandom_range(1, 400));
            av = !live_sz.exists(cu * 64 + wg) && ($urandom_range(0, 3) != 0);
            dv = (live_q.size() > 0) && ($urandom_range(0, 4) == 0);
            dkey = 0;
            if (dv) dkey = live_q[$urandom_range(0, live_q.size() - 1)];
            do_cycle(av, cu, wg, sz, dv, dkey / 64, dkey % 64, ha, hd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
